// File: rtl/fir_pkg.sv
// Shared FIR datapath widths and output saturation limits,
// common to the MAC stage and the output stage.
package fir_pkg;

    localparam int FIR_ACC_W = 48;
    localparam int FIR_OUT_W = 24;
    localparam int FIR_SHIFT = 23;

    localparam logic signed [FIR_OUT_W-1:0] SAT_MAX =
        {1'b0, {(FIR_OUT_W-1){1'b1}}};
    localparam logic signed [FIR_OUT_W-1:0] SAT_MIN =
        {1'b1, {(FIR_OUT_W-1){1'b0}}};

endpackage

// File: rtl/fir_out_fifo.sv
// Output sample FIFO: power-of-two depth, registered not-empty flag,
// head entry presented combinationally (zero while empty).
module fir_out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW:0]   cnt_q;
    logic [PW:0]   cnt_d;
    logic          valid_q;
    logic          rd;
    logic          wr;

    assign rd     = rd_i && valid_q;
    assign full_o = (cnt_q == (PW+1)'(DEPTH));
    // A full FIFO still takes a write when the head leaves the same cycle
    assign wr     = wr_i && (!full_o || rd);
    assign cnt_d  = cnt_q + (PW+1)'(wr) - (PW+1)'(rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr) wptr_q <= wptr_q + PW'(1);
            if (rd) rptr_q <= rptr_q + PW'(1);
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= wr_data_i;
    end

    assign valid_o = valid_q;
    assign data_o  = valid_q ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: round, saturate, decimate, then buffer samples
// in a small FIFO with sticky saturation/drop status.
module fir_out_stage
    import fir_pkg::*;
#(
    parameter int ACC_W = FIR_ACC_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_SHIFT,
    parameter int DEPTH = 4,
    parameter int DEC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] in_data,
    input  logic [DEC_W-1:0]        decim,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    input  logic                    clr_flags,
    output logic                    sat_flag,
    output logic                    drop_flag,
    output logic [15:0]             drop_count
);

    localparam int AW = ACC_W + 1 - SHIFT;
    localparam logic signed [ACC_W:0] RND =
        {{AW{1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [AW-1:0] MAXV =
        {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0]   sum;
    logic                    unused_lsb;
    logic                    a_vld_q;
    logic                    b_vld_q;
    logic signed [AW-1:0]    a_q;
    logic signed [OUT_W-1:0] b_q;
    logic signed [OUT_W-1:0] b_d;
    logic                    clamp;
    logic [DEC_W-1:0]        cnt_q;
    logic [DEC_W-1:0]        cnt_d;
    logic                    fwd;
    logic                    wrap;
    logic                    full;
    logic                    drop;
    logic                    sat_q;
    logic                    drop_q;
    logic [15:0]             dcnt_q;

    // One extra bit so the rounding offset can never wrap
    assign sum        = $signed({in_data[ACC_W-1], in_data}) + RND;
    assign unused_lsb = ^sum[SHIFT-1:0];

    always_comb begin
        b_d   = a_q[OUT_W-1:0];
        clamp = 1'b0;
        if (a_q > MAXV) begin
            b_d   = MAXV[OUT_W-1:0];
            clamp = 1'b1;
        end else if (a_q < MINV) begin
            b_d   = MINV[OUT_W-1:0];
            clamp = 1'b1;
        end
    end

    assign fwd   = b_vld_q && (cnt_q == '0);
    assign wrap  = (decim <= DEC_W'(1)) ||
                   (cnt_q >= decim - DEC_W'(1));
    assign cnt_d = wrap ? '0 : cnt_q + DEC_W'(1);
    assign drop  = fwd && full && !(out_valid && out_ready);

    always_ff @(posedge clk) begin
        if (in_valid) a_q <= sum[ACC_W:SHIFT];
        if (a_vld_q)  b_q <= b_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            a_vld_q <= in_valid;
            b_vld_q <= a_vld_q;
            if (b_vld_q) cnt_q <= cnt_d;
            if (a_vld_q && clamp) sat_q <= 1'b1;
            else if (clr_flags)   sat_q <= 1'b0;
            // A coincident event beats the clear
            if (drop) begin
                drop_q <= 1'b1;
                if (clr_flags)    dcnt_q <= 16'd1;
                else if (~&dcnt_q) dcnt_q <= dcnt_q + 16'd1;
            end else if (clr_flags) begin
                drop_q <= 1'b0;
                dcnt_q <= '0;
            end
        end
    end

    fir_out_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_i      (fwd),
        .wr_data_i (b_q),
        .rd_i      (out_ready),
        .valid_o   (out_valid),
        .data_o    (out_data),
        .full_o    (full)
    );

    assign sat_flag   = sat_q;
    assign drop_flag  = drop_q;
    assign drop_count = dcnt_q;

endmodule

// File: tb/tb_fir_out_stage.sv
// Scoreboard bench for fir_out_stage: directed corner cases plus
// randomized traffic against an arithmetic reference model.
module tb_fir_out_stage;
    import fir_pkg::*;

    localparam int AW    = 48;
    localparam int OW    = 24;
    localparam int SH    = 23;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [AW-1:0] in_data;
    logic [DW-1:0]        decim;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;
    logic                 clr_flags;
    logic                 sat_flag;
    logic                 drop_flag;
    logic [15:0]          drop_count;

    always #5 clk = ~clk;

    fir_out_stage #(
        .ACC_W (AW),
        .OUT_W (OW),
        .SHIFT (SH),
        .DEPTH (DEPTH),
        .DEC_W (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .decim      (decim),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .clr_flags  (clr_flags),
        .sat_flag   (sat_flag),
        .drop_flag  (drop_flag),
        .drop_count (drop_count)
    );

    int                   tests = 0;
    int                   fails = 0;
    logic signed [OW-1:0] sbq[$];
    int                   outstanding = 0;
    int                   mcnt = 0;
    bit                   mon_en = 1'b0;

    task automatic check(string name, logic signed [63:0] act,
                         logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Round half toward +inf, then clamp to the output range
    function automatic logic signed [OW-1:0] model(longint x);
        longint r;
        r = (x + (longint'(1) <<< (SH - 1))) >>> SH;
        if (r > longint'(SAT_MAX)) r = longint'(SAT_MAX);
        if (r < longint'(SAT_MIN)) r = longint'(SAT_MIN);
        return r[OW-1:0];
    endfunction

    function automatic bit decide(int d);
        bit f;
        f = (mcnt == 0);
        if (d <= 1 || mcnt >= d - 1) mcnt = 0;
        else mcnt++;
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(longint x, bit keep);
        bit f;
        in_valid = 1'b1;
        in_data  = x[AW-1:0];
        f = decide(int'(decim));
        if (f && keep) begin
            sbq.push_back(model(x));
            outstanding++;
        end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || outstanding != 0) && n < 300) begin
            cyc();
            n++;
        end
        check({name, "_drain_left"}, sbq.size(), 0);
        repeat (4) cyc();
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid === 1'b1 && out_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0d required none",
                         out_data);
            end else begin
                check("out_data", out_data, sbq.pop_front());
                outstanding--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dsel[6];
        longint v;
        dsel = '{0, 1, 2, 3, 5, 7};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        decim     = 8'd1;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_drop_flag", drop_flag, 0);
        check("rst_drop_count", drop_count, 0);
        mon_en = 1'b1;
        cyc();

        issue(29360128, 1'b1);
        @(negedge clk);
        check("lat_c1_valid", out_valid, 0);
        cyc();
        @(negedge clk);
        check("lat_c2_valid", out_valid, 0);
        cyc();
        @(negedge clk);
        check("lat_c3_valid", out_valid, 1);
        cyc();
        issue(-4194304, 1'b1);
        drain("round");

        issue((longint'(1) <<< 47) - 1, 1'b1);
        issue(-(longint'(1) <<< 47), 1'b1);
        drain("sat");
        check("sat_flag_set", sat_flag, 1);
        pulse_clr();
        @(negedge clk);
        check("sat_flag_clr", sat_flag, 0);
        cyc();

        decim = 8'd3;
        for (int i = 1; i <= 9; i++) issue(longint'(i) <<< SH, 1'b1);
        drain("decim3");
        decim = 8'd1;

        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) issue(longint'(i) <<< SH, i <= 4);
        repeat (6) cyc();
        @(negedge clk);
        check("drop_count_2", drop_count, 2);
        check("drop_flag_set", drop_flag, 1);
        cyc();
        out_ready = 1'b1;
        drain("drop");

        pulse_clr();
        @(negedge clk);
        check("drop_count_clr", drop_count, 0);
        cyc();
        out_ready = 1'b0;
        for (int i = 11; i <= 14; i++) issue(longint'(i) <<< SH, 1'b1);
        repeat (4) cyc();
        issue(longint'(15) <<< SH, 1'b1);
        cyc();
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        check("fullrw_drop_count", drop_count, 0);
        check("fullrw_drop_flag", drop_flag, 0);
        cyc();
        drain("fullrw");

        out_ready = 1'b0;
        for (int i = 21; i <= 24; i++) issue(longint'(i) <<< SH, 1'b1);
        repeat (4) cyc();
        issue(longint'(25) <<< SH, 1'b0);
        cyc();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        @(negedge clk);
        check("clr_vs_drop_count", drop_count, 1);
        check("clr_vs_drop_flag", drop_flag, 1);
        cyc();
        out_ready = 1'b1;
        drain("clrdrop");
        pulse_clr();

        for (int b = 0; b < 6; b++) begin
            decim = DW'(dsel[$urandom_range(0, 5)]);
            for (int c = 0; c < 60; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (outstanding < DEPTH && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 2))
                        0: v = longint'($signed($urandom));
                        1: v = (longint'($signed($urandom)) <<< 16)
                               + longint'($urandom_range(0, 65535));
                        default: v = (longint'($signed($urandom_range(0, 200)))
                                     - 100) * (longint'(1) <<< (SH - 1));
                    endcase
                    issue(v, 1'b1);
                end else begin
                    cyc();
                end
            end
            out_ready = 1'b1;
            drain("rand");
        end
        @(negedge clk);
        check("rand_drop_count", drop_count, 0);
        check("rand_drop_flag", drop_flag, 0);
        cyc();

        decim = 8'd1;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) issue(longint'(i) <<< SH, 1'b1);
        repeat (4) cyc();
        issue(longint'(4) <<< SH, 1'b1);
        issue(longint'(5) <<< SH, 1'b1);
        mon_en = 1'b0;
        reset  = 1'b1;
        cyc();
        reset = 1'b0;
        sbq.delete();
        outstanding = 0;
        mcnt = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        cyc();
        out_ready = 1'b1;
        mon_en = 1'b1;
        repeat (10) cyc();
        @(negedge clk);
        check("midrst_quiet", out_valid, 0);
        cyc();
        issue(longint'(6) <<< SH, 1'b1);
        drain("postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_out_stage.md
FIR_OUT_STAGE -- requirements
Module: fir_out_stage

Interface
REQ-001 Parameter ACC_W, default 48, width of the accumulator input.
REQ-002 Parameter OUT_W, default 24, width of the output sample.
REQ-003 Parameter SHIFT, default 23, right-shift (fraction bits) applied before saturation.
REQ-004 Parameter DEPTH, default 4, output FIFO depth (power of two, >= 2).
REQ-005 Parameter DEC_W, default 8, width of the decimation-factor input.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  qualifies in_data; no backpressure upstream.
REQ-009 in_data  in  ACC_W signed  accumulator result from the last FIR MAC stage.
REQ-010 decim  in  DEC_W  decimation factor; 0 and 1 both mean "pass every sample".
REQ-011 out_valid  out  1  FIFO head valid.
REQ-012 out_ready  in  1  downstream accepts head when out_valid && out_ready.
REQ-013 out_data  out  OUT_W signed  rounded, saturated sample.
REQ-014 clr_flags  in  1  clears sat_flag, drop_flag, drop_count.
REQ-015 sat_flag  out  1  sticky: saturation occurred.
REQ-016 drop_flag  out  1  sticky: sample lost on full FIFO.
REQ-017 drop_count  out  16  dropped-sample count, saturates at 0xFFFF.

Function
REQ-018 Stage A (1 cycle, loads on in_valid): add 2^(SHIFT-1) in ACC_W+1 bits (no wrap), arithmetic shift right by SHIFT; round half toward +inf.
REQ-019 Stage B (1 cycle): clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clamp sets sat_flag.
REQ-020 Valid SHALL propagate A->B one register per stage; data registers hold when their valid is low.
REQ-021 Decimation counter cnt: on each stage-B valid, sample is forwarded iff cnt==0; cnt_next = (cnt >= decim-1 or decim<=1) ? 0 : cnt+1.
REQ-022 A change of decim SHALL take effect at the next stage-B valid with no reset of cnt, except cnt >= new decim-1 forces wrap to 0.
REQ-023 Forwarded sample SHALL be written to the FIFO at the following edge; with FIFO empty and out_ready high, in_valid at cycle 0 gives out_valid at cycle 3.
REQ-024 out_valid SHALL be registered and equal "FIFO not empty"; out_data SHALL be the head entry, stable while out_valid && !out_ready.
REQ-025 Write to full FIFO with no same-cycle read: sample dropped, drop_flag set, drop_count incremented (saturating).
REQ-026 Write to full FIFO with same-cycle read: write accepted, no drop.
REQ-027 Simultaneous read and write when empty: write stored, out_valid high next cycle.
REQ-028 FIFO order SHALL be strict first-in-first-out; pointers wrap modulo DEPTH.
REQ-029 clr_flags coincident with a saturation or drop event: event wins (flag set, drop_count = 1).

Reset
REQ-030 Reset SHALL clear stage valids, cnt, FIFO pointers/occupancy, sat_flag, drop_flag, drop_count; out_valid=0 and out_data=0 the cycle after reset.
REQ-031 Reset mid-stream SHALL discard all in-flight and buffered samples; no post-reset output until a new in_valid.
REQ-032 Data registers other than out_data need no reset.

Structure
REQ-033 Shared package fir_pkg SHALL hold ACC_W, OUT_W, SHIFT defaults and the saturation min/max constants, shared with the FIR MAC stage.
REQ-034 FIFO SHALL be a sub-module fir_out_fifo (DEPTH x OUT_W, full/empty, registered valid); rounding, saturation, decimation stay in fir_out_stage.

Verification (SHIFT=23, OUT_W=24, DEPTH=4)
REQ-035 in_data=29360128 (3.5), out_ready=1 -> out_data=4 with out_valid at cycle 3; in_data=-4194304 (-0.5) -> 0.
REQ-036 in_data=2^47-1 -> out_data=8388607, sat_flag=1; in_data=-2^47 -> -8388608; clr_flags -> sat_flag=0.
REQ-037 decim=3, inputs 1..9 (x2^23) -> outputs exactly 1,4,7.
REQ-038 out_ready=0, six samples 1..6 -> drop_count=2, drop_flag=1; then out_ready=1 -> outputs 1,2,3,4 in order.
REQ-039 FIFO full, out_ready=1 and new sample same cycle -> no drop, drop_count unchanged, order preserved.
REQ-040 reset asserted with 3 samples buffered and 2 in pipeline -> out_valid=0 next cycle, no stale sample emitted afterwards.
